// File: rtl/sisc_mem_resp_if.sv
// Request/response bus between the SISC control path and the memory responder.
// The master drives the request fields. The slave returns the response strobe and read data.
interface sisc_mem_resp_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              busy;
    logic              err;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ack, busy, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ack, busy, err
    );
endinterface

// File: rtl/sisc_mem_resp.sv
// Word-addressed unified memory for the SISC multi-cycle datapath.
// It uses a req/ack handshake, programmable read/write wait states and out-of-range error flagging.
module sisc_mem_resp #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 1
) (
    input logic             clk,
    input logic             rst,
    sisc_mem_resp_if.slave  bus
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [3:0] RD_W = 4'(RD_WAIT);
    localparam logic [3:0] WR_W = 4'(WR_WAIT);

    generate
        if (RD_WAIT < 0 || RD_WAIT > 15) begin : g_bad_rd_wait
            $error("sisc_mem_resp: RD_WAIT must be in 0..15");
        end
        if (WR_WAIT < 0 || WR_WAIT > 15) begin : g_bad_wr_wait
            $error("sisc_mem_resp: WR_WAIT must be in 0..15");
        end
        if (DEPTH < 1 || IDX_W > ADDR_W) begin : g_bad_depth
            $error("sisc_mem_resp: DEPTH must fit the ADDR_W address space");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [3:0]        cnt, cnt_next;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              oor_q;
    logic [DATA_W-1:0] rdata_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic [3:0]        w_load;
    logic              enter_resp;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_in_range;
    logic [IDX_W-1:0]  acc_idx;

    assign accept = (state == IDLE) && bus.req;
    assign w_load = bus.we ? WR_W : RD_W;

    // A zero-wait request enters RESP on its own sampling edge.
    // The RAM access must then use the live inputs, not the latched copy.
    assign acc_we       = accept ? bus.we    : we_q;
    assign acc_addr     = accept ? bus.addr  : addr_q;
    assign acc_wdata    = accept ? bus.wdata : wdata_q;
    assign acc_in_range = ({1'b0, acc_addr} < DEPTH_L);
    assign acc_idx      = acc_addr[IDX_W-1:0];
    assign enter_resp   = (state_next == RESP);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            IDLE: begin
                if (bus.req) begin
                    if (w_load == 4'd0) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = w_load - 4'd1;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_next = RESP;
                else             cnt_next   = cnt - 4'd1;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            oor_q   <= 1'b0;
        end else if (accept) begin
            we_q    <= bus.we;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            oor_q   <= ({1'b0, bus.addr} >= DEPTH_L);
        end
    end

    // NOTE: the RAM array has no reset so it can map onto block RAM.
    // rst only blocks the write enable, so an aborted access cannot land.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && acc_we && acc_in_range) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (enter_resp && !acc_we) begin
            rdata_q <= acc_in_range ? mem[acc_idx] : '0;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ack   = (state == RESP);
    assign bus.busy  = (state != IDLE);
    assign bus.err   = (state == RESP) && oor_q;

endmodule

// File: tb/tb_sisc_mem_resp.sv
// Self-checking bench for sisc_mem_resp: three instances with different wait-state settings.
// A transaction-level model is checked every cycle, alongside directed literal checks.
module tb_sisc_mem_resp;

    localparam int N = 3;
    localparam int RDW [N] = '{2, 0, 1};
    localparam int WRW [N] = '{1, 4, 0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] rst_v = '1;
    logic [N-1:0] req_v = '0;
    logic [N-1:0] we_v  = '0;
    logic [15:0]  addr_v  [N];
    logic [31:0]  wdata_v [N];
    wire  [N-1:0] ack_o, busy_o, err_o;
    wire  [31:0]  rdata_o [N];

    sisc_mem_resp_if if_a ();
    sisc_mem_resp_if if_b ();
    sisc_mem_resp_if if_c ();

    assign if_a.req = req_v[0]; assign if_a.we = we_v[0];
    assign if_a.addr = addr_v[0]; assign if_a.wdata = wdata_v[0];
    assign if_b.req = req_v[1]; assign if_b.we = we_v[1];
    assign if_b.addr = addr_v[1]; assign if_b.wdata = wdata_v[1];
    assign if_c.req = req_v[2]; assign if_c.we = we_v[2];
    assign if_c.addr = addr_v[2]; assign if_c.wdata = wdata_v[2];
    assign ack_o[0] = if_a.ack; assign busy_o[0] = if_a.busy;
    assign err_o[0] = if_a.err; assign rdata_o[0] = if_a.rdata;
    assign ack_o[1] = if_b.ack; assign busy_o[1] = if_b.busy;
    assign err_o[1] = if_b.err; assign rdata_o[1] = if_b.rdata;
    assign ack_o[2] = if_c.ack; assign busy_o[2] = if_c.busy;
    assign err_o[2] = if_c.err; assign rdata_o[2] = if_c.rdata;

    sisc_mem_resp #(.ADDR_W(16), .DATA_W(32), .DEPTH(1024), .RD_WAIT(2), .WR_WAIT(1))
        dut_a (.clk(clk), .rst(rst_v[0]), .bus(if_a));
    sisc_mem_resp #(.ADDR_W(16), .DATA_W(32), .DEPTH(1024), .RD_WAIT(0), .WR_WAIT(4))
        dut_b (.clk(clk), .rst(rst_v[1]), .bus(if_b));
    sisc_mem_resp #(.ADDR_W(16), .DATA_W(32), .DEPTH(1024), .RD_WAIT(1), .WR_WAIT(0))
        dut_c (.clk(clk), .rst(rst_v[2]), .bus(if_c));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a request accepted at edge e completes at edge e+W.
    // Ack is high in the cycle after edge e+W. The next acceptance is possible from edge e+W+2.
    logic [31:0] mem_m [int];
    bit          pend   [N];
    int          done_e [N];
    logic        we_m   [N];
    logic [15:0] a_m    [N];
    logic [31:0] wd_m   [N];
    logic [31:0] rd_m   [N];
    int          edge_n = 0;

    initial begin
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; done_e[i] = 0; rd_m[i] = '0;
            we_m[i] = 1'b0; a_m[i] = '0; wd_m[i] = '0;
            addr_v[i] = '0; wdata_v[i] = '0;
        end
    end

    always @(posedge clk) begin
        edge_n++;
        for (int i = 0; i < N; i++) begin
            if (rst_v[i]) begin
                pend[i] = 1'b0;
                rd_m[i] = '0;
            end else begin
                if (!pend[i] || edge_n >= done_e[i] + 2) begin
                    pend[i] = 1'b0;
                    if (req_v[i]) begin
                        pend[i]   = 1'b1;
                        we_m[i]   = we_v[i];
                        a_m[i]    = addr_v[i];
                        wd_m[i]   = wdata_v[i];
                        done_e[i] = edge_n + (we_v[i] ? WRW[i] : RDW[i]);
                    end
                end
                if (pend[i] && edge_n == done_e[i]) begin
                    if (a_m[i] < 16'd1024) begin
                        if (we_m[i]) mem_m[(i << 16) | int'(a_m[i])] = wd_m[i];
                        else if (mem_m.exists((i << 16) | int'(a_m[i])))
                            rd_m[i] = mem_m[(i << 16) | int'(a_m[i])];
                        else rd_m[i] = 'x;
                    end else if (!we_m[i]) begin
                        rd_m[i] = '0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            logic e_ack, e_busy, e_err;
            logic [31:0] e_rd;
            e_ack  = !rst_v[i] && pend[i] && edge_n == done_e[i];
            e_busy = !rst_v[i] && pend[i] && edge_n <= done_e[i];
            e_err  = e_ack && (a_m[i] >= 16'd1024);
            e_rd   = rst_v[i] ? 32'h0 : rd_m[i];
            check($sformatf("model_ack[%0d]", i),   32'(ack_o[i]),  32'(e_ack));
            check($sformatf("model_busy[%0d]", i),  32'(busy_o[i]), 32'(e_busy));
            check($sformatf("model_err[%0d]", i),   32'(err_o[i]),  32'(e_err));
            check($sformatf("model_rdata[%0d]", i), rdata_o[i],     e_rd);
        end
    end

    int          lat, bsy;
    logic [31:0] rd;
    logic        er;

    // One-cycle request pulse. Inputs are scrambled after sampling, then ack is awaited (bounded).
    task automatic access(input int i, input logic w, input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        req_v[i] = 1'b1; we_v[i] = w; addr_v[i] = a; wdata_v[i] = d;
        lat = 0; bsy = 0; rd = '0; er = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) begin
                req_v[i] = 1'b0; we_v[i] = ~w; addr_v[i] = a ^ 16'h0001; wdata_v[i] = ~d;
            end
            if (busy_o[i]) bsy++;
            if (ack_o[i]) begin
                lat = n; rd = rdata_o[i]; er = err_o[i];
                break;
            end
        end
        if (lat == 0) check($sformatf("ack_timeout[%0d]", i), 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset_ack",   32'(ack_o[0]),  32'd0);
        check("reset_busy",  32'(busy_o[0]), 32'd0);
        check("reset_err",   32'(err_o[0]),  32'd0);
        check("reset_rdata", rdata_o[0],     32'h0);
        rst_v = '0;

        // Instance A: RD_WAIT=2, WR_WAIT=1
        access(0, 1'b1, 16'd5, 32'h8100_0003);
        check("a_wr5_lat", 32'(lat), 32'd2);
        access(0, 1'b0, 16'd5, 32'h0);
        check("a_rd5_lat",   32'(lat), 32'd3);
        check("a_rd5_busy",  32'(bsy), 32'd3);
        check("a_rd5_data",  rd,       32'h8100_0003);
        check("a_rd5_err",   32'(er),  32'd0);
        access(0, 1'b1, 16'd7, 32'hDEAD_BEEF);
        check("a_wr7_lat",   32'(lat), 32'd2);
        check("a_wr7_rdata", rd,       32'h8100_0003);
        access(0, 1'b0, 16'd7, 32'h0);
        check("a_rd7_data",  rd,       32'hDEAD_BEEF);
        access(0, 1'b0, 16'd1024, 32'h0);
        check("a_oor_rd_err",  32'(er), 32'd1);
        check("a_oor_rd_data", rd,      32'h0);
        access(0, 1'b1, 16'd1023, 32'h5555_AAAA);
        check("a_wr1023_err", 32'(er), 32'd0);
        access(0, 1'b1, 16'hFFFF, 32'h0BAD_F00D);
        check("a_oor_wr_err", 32'(er), 32'd1);
        check("a_oor_wr_lat", 32'(lat), 32'd2);
        access(0, 1'b0, 16'd1023, 32'h0);
        check("a_probe1023", rd, 32'h5555_AAAA);
        check("a_probe_err", 32'(er), 32'd0);

        // Instance B: RD_WAIT=0, WR_WAIT=4
        for (int a = 10; a <= 17; a++) begin
            access(1, 1'b1, 16'(a), 32'hB000_0000 + 32'(a));
            check("b_wr_lat", 32'(lat), 32'd5);
        end
        access(1, 1'b1, 16'd3, 32'h0);

        // Held req: acceptance only every other edge, addr picked up at acceptance.
        @(negedge clk);
        req_v[1] = 1'b1; we_v[1] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            addr_v[1] = 16'(10 + k);
            @(negedge clk);
            check($sformatf("b_held_ack_c%0d", k + 1), 32'(ack_o[1]), 32'((k % 2) == 0));
            if ((k % 2) == 0)
                check($sformatf("b_held_data_c%0d", k + 1), rdata_o[1], 32'hB000_0000 + 32'(10 + k));
        end
        req_v[1] = 1'b0;

        // Reset during WAIT aborts the write.
        @(negedge clk);
        req_v[1] = 1'b1; we_v[1] = 1'b1; addr_v[1] = 16'd3; wdata_v[1] = 32'h1234;
        @(negedge clk);
        req_v[1] = 1'b0;
        @(negedge clk);
        check("b_wait_busy_pre", 32'(busy_o[1]), 32'd1);
        #2 rst_v[1] = 1'b1;
        #1;
        check("b_rst_ack",  32'(ack_o[1]),  32'd0);
        check("b_rst_busy", 32'(busy_o[1]), 32'd0);
        check("b_rst_err",  32'(err_o[1]),  32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_v[1] = 1'b0;
        access(1, 1'b0, 16'd3, 32'h0);
        check("b_rd3_after_abort", rd, 32'h0);
        check("b_rd3_lat", 32'(lat), 32'd1);

        // Instance C: WR_WAIT=0, reset while ack is high keeps the write.
        access(2, 1'b1, 16'd3, 32'h0);
        check("c_wr_lat0", 32'(lat), 32'd1);
        access(2, 1'b1, 16'd3, 32'h1234);
        check("c_wr_ack", 32'(ack_o[2]), 32'd1);
        #2 rst_v[2] = 1'b1;
        #1;
        check("c_rst_ack",  32'(ack_o[2]),  32'd0);
        check("c_rst_busy", 32'(busy_o[2]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_v[2] = 1'b0;
        access(2, 1'b0, 16'd3, 32'h0);
        check("c_rd3_lat",  32'(lat), 32'd2);
        check("c_rd3_data", rd,       32'h0000_1234);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
